kd_root_master: RTL and testbench
=================================

# kd_root_master

Tree-side initiator for the kd-tree node command protocol. It sits above the root `node` and drives that node's top-side command/data inputs. It configures the whole tree with depth/time-to-live and axis, collects the configuration acknowledge, then runs repeated sort passes until the tree reports stable. It replaces the testbench-driven top port and is the only agent that originates `start_sort`.

## Interface
Parameters:
- CMD_W, 3, command field width
- DATA_W, 16, data bus width to/from the root node
- MAX_PASSES, 16, sort passes before declaring non-convergence
- TIMEOUT, 1024, cycles allowed in any wait state before error

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- cfg_axis  in  2  initial sorting axis; captured on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE/ERROR entry
- done  out  1  one-cycle pulse on successful convergence
- error  out  1  sticky; set on timeout or pass overflow; cleared by rst or an accepted start
- pass_count  out  $clog2(MAX_PASSES+1)  sort passes completed in the current run
- command_to_child  out  CMD_W  command level to the root node
- data_to_child  out  DATA_W  data to the root node: {axis[1:0], ttl[DATA_W-3:0]}
- command_from_child  in  CMD_W  root node response level
- data_from_child  in  DATA_W  root response data; bit 0 = stable flag with sort_done

## Operation
Command codes, fixed: nop=0, depth_time_to_live=1, send_sort_ack=2, start_sort=3, sort_done=4, switch_with_top=5, switch_with_down=6, 7=reserved.

The protocol is level-based:
- A command is held on `command_to_child` until the expected response is observed on `command_from_child`.
- After the response is observed, `command_to_child` returns to nop.

States:
- IDLE: outputs nop. On `start`:
  - capture `cfg_axis`;
  - clear `pass_count` and `error`;
  - go to CONFIG.
- CONFIG: drive depth_time_to_live with data {axis, ttl=0}. Go to WAIT_CFG next cycle.
- WAIT_CFG: keep driving depth_time_to_live and data.
  - On `command_from_child == send_sort_ack`: drive nop, go to SORT.
- SORT: drive start_sort, data 0. Go to WAIT_SORT.
- WAIT_SORT: keep driving start_sort. On `command_from_child == sort_done`:
  - increment `pass_count` and drive nop;
  - if `data_from_child[0]` is set, go to DONE;
  - else if `pass_count + 1 == MAX_PASSES`, go to ERROR;
  - else go to GAP.
- GAP: one nop cycle so the root observes the release. Then go to SORT.
- DONE: pulse `done`, go to IDLE.
- ERROR: set `error`, drive nop, go to IDLE.

Other rules:
- Any response other than the expected one in a wait state is ignored. switch_with_* codes are node-to-node only.
- The timeout counter resets on each state entry and counts in WAIT_CFG and WAIT_SORT. Reaching TIMEOUT-1 enters ERROR.
- `start` while busy is ignored.

## Timing
- Reset values: `command_to_child`=nop, `data_to_child`=0, `busy`=0, `done`=0, `error`=0, `pass_count`=0, state IDLE.
- All outputs are registered. A command appears the cycle after entering the driving state.
  - `start` at cycle N gives `command_to_child`=depth_time_to_live at N+2.
- The response is sampled registered. Nop is driven the cycle after the matching response is seen.
- Minimum gap between consecutive start_sort assertions is 2 cycles of nop.
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` rises.
- `rst` mid-run returns to IDLE in one cycle with nop driven. The root node is also reset by the same `rst`.
- A response present in the same cycle as a timeout expiry takes priority: the response is accepted, no error.

## Structure
- Package `kd_tree_pkg`:
  - command localparams (nop … switch_with_down);
  - state enum;
  - the data-field packing helpers (axis position, ttl width).
  - `node` must import the same package.
- One sub-module, `kd_wait_timer`: loadable down-counter with expire flag, reused by both wait states.
- The FSM itself stays in `kd_root_master`.

## Test plan
- Nominal: `start`, `cfg_axis`=2 -> `data_to_child`=0x8000 with depth_time_to_live. Model acks after 5 cycles -> start_sort issued. sort_done with stable=1 on pass 1 -> `done` pulse, `pass_count`=1.
- Multi-pass: model returns stable=0 three times, then 1 -> four start_sort assertions each separated by ≥2 nop cycles, `pass_count`=4, `done`.
- Non-convergence: MAX_PASSES=4, always stable=0 -> `error`=1 after pass 4, no `done`, nop driven.
- Timeout: no ack in WAIT_CFG, TIMEOUT=16 -> `error` 16 cycles after entry. Ack arriving exactly at expiry -> accepted, no error.
- Reset mid-WAIT_SORT: assert `rst` one cycle -> next cycle `command_to_child`=nop, `busy`=0, `pass_count`=0.
- Spurious responses: inject switch_with_top and sort_done during WAIT_CFG -> ignored, command held until send_sort_ack; `start` during busy ignored.

Source files
------------

// File: rtl/kd_tree_pkg.sv
// rtl/kd_tree_pkg.sv - shared command codes, FSM states and data-field layout for the kd-tree
package kd_tree_pkg;

  localparam logic [2:0] CMD_NOP              = 3'd0;
  localparam logic [2:0] CMD_DEPTH_TTL        = 3'd1;
  localparam logic [2:0] CMD_SEND_SORT_ACK    = 3'd2;
  localparam logic [2:0] CMD_START_SORT       = 3'd3;
  localparam logic [2:0] CMD_SORT_DONE        = 3'd4;
  localparam logic [2:0] CMD_SWITCH_WITH_TOP  = 3'd5;
  localparam logic [2:0] CMD_SWITCH_WITH_DOWN = 3'd6;

  // Data word layout: axis in the top AXIS_W bits, ttl below it.
  localparam int AXIS_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONFIG,
    ST_WAIT_CFG,
    ST_SORT,
    ST_WAIT_SORT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } kd_state_e;

  function automatic int ttl_width(input int data_w);
    return data_w - AXIS_W;
  endfunction

endpackage

// File: rtl/kd_wait_timer.sv
// rtl/kd_wait_timer.sv - loadable down-counter; expired is high once the count reaches zero
module kd_wait_timer #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Saturates at zero so a stalled wait keeps reporting expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/kd_root_master.sv
// rtl/kd_root_master.sv - kd-tree root initiator: configures the tree, then runs sort passes until stable
module kd_root_master
  import kd_tree_pkg::*;
#(
  parameter int CMD_W      = 3,
  parameter int DATA_W     = 16,
  parameter int MAX_PASSES = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [1:0]                       cfg_axis,
  output logic                             busy,
  output logic                             done,
  output logic                             error,
  output logic [$clog2(MAX_PASSES+1)-1:0]  pass_count,
  output logic [CMD_W-1:0]                 command_to_child,
  output logic [DATA_W-1:0]                data_to_child,
  input  logic [CMD_W-1:0]                 command_from_child,
  input  logic [DATA_W-1:0]                data_from_child
);

  localparam int TTL_W   = ttl_width(DATA_W);
  localparam int TIMER_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CMD_W-1:0] C_NOP        = CMD_W'(CMD_NOP);
  localparam logic [CMD_W-1:0] C_DEPTH_TTL  = CMD_W'(CMD_DEPTH_TTL);
  localparam logic [CMD_W-1:0] C_ACK        = CMD_W'(CMD_SEND_SORT_ACK);
  localparam logic [CMD_W-1:0] C_START_SORT = CMD_W'(CMD_START_SORT);
  localparam logic [CMD_W-1:0] C_SORT_DONE  = CMD_W'(CMD_SORT_DONE);
  localparam logic [TTL_W-1:0] TTL_INIT     = '0;

  kd_state_e             state;
  kd_state_e             state_next;
  logic [AXIS_W-1:0]     axis_q;
  logic [CMD_W-1:0]      cmd_next;
  logic [DATA_W-1:0]     data_next;
  logic                  pass_inc;
  logic                  accept_start;
  logic                  in_wait;
  logic                  expired;
  logic                  unused_resp_bits;

  assign accept_start     = (state == ST_IDLE) && start;
  assign in_wait          = (state == ST_WAIT_CFG) || (state == ST_WAIT_SORT);
  assign unused_resp_bits = ^data_from_child[DATA_W-1:1];

  // Reloaded in every non-wait state, so each wait starts with a full budget.
  kd_wait_timer #(
    .WIDTH (TIMER_W)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (!in_wait),
    .load_value (TIMER_W'(TIMEOUT - 1)),
    .enable     (in_wait),
    .expired    (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_next   = C_NOP;
    data_next  = '0;
    pass_inc   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_CONFIG;
      end
      ST_CONFIG: begin
        cmd_next   = C_DEPTH_TTL;
        data_next  = {axis_q, TTL_INIT};
        state_next = ST_WAIT_CFG;
      end
      ST_WAIT_CFG: begin
        // Response wins over a coincident expiry.
        if (command_from_child == C_ACK) begin
          state_next = ST_SORT;
        end else if (expired) begin
          state_next = ST_ERROR;
        end else begin
          cmd_next  = C_DEPTH_TTL;
          data_next = {axis_q, TTL_INIT};
        end
      end
      ST_SORT: begin
        cmd_next   = C_START_SORT;
        state_next = ST_WAIT_SORT;
      end
      ST_WAIT_SORT: begin
        if (command_from_child == C_SORT_DONE) begin
          pass_inc = 1'b1;
          if (data_from_child[0]) begin
            state_next = ST_DONE;
          end else if (int'(pass_count) + 1 == MAX_PASSES) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_GAP;
          end
        end else if (expired) begin
          state_next = ST_ERROR;
        end else begin
          cmd_next = C_START_SORT;
        end
      end
      ST_GAP:   state_next = ST_SORT;
      ST_DONE:  state_next = ST_IDLE;
      ST_ERROR: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // done/error/busy look ahead one state so they line up with DONE/ERROR entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      axis_q           <= '0;
      command_to_child <= C_NOP;
      data_to_child    <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      pass_count       <= '0;
    end else begin
      command_to_child <= cmd_next;
      data_to_child    <= data_next;
      busy             <= !(state_next inside {ST_IDLE, ST_DONE, ST_ERROR});
      done             <= (state_next == ST_DONE);
      if (accept_start) begin
        axis_q     <= cfg_axis;
        pass_count <= '0;
        error      <= 1'b0;
      end else begin
        if (pass_inc) pass_count <= pass_count + 1'b1;
        if (state_next == ST_ERROR) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kd_root_master.sv
// tb/tb_kd_root_master.sv - randomized self-checking bench for kd_root_master with a reactive root-node model
module tb_kd_root_master;

  localparam int MAX_PASSES = 4;
  localparam int TIMEOUT    = 16;
  localparam int PC_W       = $clog2(MAX_PASSES + 1);

  localparam logic [2:0] C_NOP = 3'd0, C_DTL = 3'd1, C_ACK = 3'd2, C_SORT = 3'd3;
  localparam logic [2:0] C_SDONE = 3'd4, C_SWT = 3'd5, C_SWD = 3'd6;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [1:0]      cfg_axis;
  logic            busy;
  logic            done;
  logic            error;
  logic [PC_W-1:0] pass_count;
  logic [2:0]      command_to_child;
  logic [15:0]     data_to_child;
  logic [2:0]      command_from_child;
  logic [15:0]     data_from_child;

  int vectors = 0;
  int miscompares = 0;

  // Observations gathered by run()
  int          o_dtl_first, o_dtl_phases, o_sorts, o_min_gap, o_done_cycles;
  int          o_err_at, o_err_cycles, o_pc_end, o_nop_after;
  bit          o_busy_bad, o_bad_data, o_hung, o_err_clear_bad;
  logic [15:0] o_cfg_data;

  always #5 clk = ~clk;

  kd_root_master #(
    .CMD_W      (3),
    .DATA_W     (16),
    .MAX_PASSES (MAX_PASSES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .cfg_axis           (cfg_axis),
    .busy               (busy),
    .done               (done),
    .error              (error),
    .pass_count         (pass_count),
    .command_to_child   (command_to_child),
    .data_to_child      (data_to_child),
    .command_from_child (command_from_child),
    .data_from_child    (data_from_child)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] pick_spur(input bit in_cfg);
    logic [1:0] r;
    r = 2'($urandom);
    if (in_cfg) begin
      case (r)
        2'd0:    return C_SWT;
        2'd1:    return C_SDONE;
        2'd2:    return C_SWD;
        default: return C_SORT;
      endcase
    end else begin
      case (r)
        2'd0:    return C_SWT;
        2'd1:    return C_ACK;
        2'd2:    return C_SWD;
        default: return C_DTL;
      endcase
    end
  endfunction

  // Pass-by-pass outcome of one run from the protocol rules.
  task automatic model(input int ack_delay, input int stable_pass, input int sort_delay,
                       output bit exp_done, output int exp_pc, output int exp_sorts);
    exp_done = 0; exp_pc = 0; exp_sorts = 0;
    if (ack_delay >= TIMEOUT) return;
    for (int p = 1; p <= MAX_PASSES; p++) begin
      exp_sorts = p;
      if (sort_delay >= TIMEOUT) return;
      exp_pc = p;
      if (p == stable_pass) begin
        exp_done = 1;
        return;
      end
    end
  endtask

  // Root-node model: answers the held command after a delay, optionally with noise.
  task automatic run(input logic [1:0] axis, input int ack_delay, input int stable_pass,
                     input int sd_min, input int sd_max, input bit spurious, input bit poke);
    int hold, pass, nop_run, sdelay, end_cyc;
    bit seen_sort, responding, fin;
    logic [2:0] prev;
    logic [31:0] r;
    o_dtl_first = -1; o_dtl_phases = 0; o_sorts = 0; o_min_gap = 1000; o_done_cycles = 0;
    o_err_at = -1; o_err_cycles = 0; o_pc_end = -1; o_nop_after = 0;
    o_busy_bad = 0; o_bad_data = 0; o_hung = 0; o_err_clear_bad = 0; o_cfg_data = 16'hxxxx;
    hold = 0; pass = 0; nop_run = 0; end_cyc = 0; seen_sort = 0; responding = 0; fin = 0;
    prev = C_NOP;
    sdelay = $urandom_range(sd_max, sd_min);
    cfg_axis = axis;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_axis = ~axis;
    if (error !== 1'b0) o_err_clear_bad = 1;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (command_to_child == C_DTL) begin
        if (prev != C_DTL) begin
          o_dtl_phases++;
          if (o_dtl_first < 0) begin
            o_dtl_first = cyc;
            o_cfg_data = data_to_child;
          end
        end
        if (data_to_child !== {axis, 14'h0}) o_bad_data = 1;
      end
      if (command_to_child == C_SORT) begin
        if (prev != C_SORT) begin
          o_sorts++;
          if (seen_sort && nop_run < o_min_gap) o_min_gap = nop_run;
          seen_sort = 1;
        end
        if (data_to_child !== 16'h0) o_bad_data = 1;
      end
      nop_run = (command_to_child == C_NOP) ? nop_run + 1 : 0;
      if (done === 1'b1) begin
        o_done_cycles++;
        if (busy !== 1'b0) o_busy_bad = 1;
        if (!fin) o_pc_end = pass_count;
      end
      if (error === 1'b1) begin
        o_err_cycles++;
        if (o_err_at < 0) begin
          o_err_at = cyc;
          o_pc_end = pass_count;
          if (busy !== 1'b0) o_busy_bad = 1;
        end
      end
      if (!fin && (done === 1'b1 || error === 1'b1)) begin
        fin = 1;
        end_cyc = cyc;
      end else if (!fin && busy !== 1'b1) begin
        o_busy_bad = 1;
      end
      if (fin && command_to_child !== C_NOP) o_nop_after++;
      if (fin && cyc >= end_cyc + 4) break;
      case (command_to_child)
        C_DTL: begin
          hold++;
          if (hold > ack_delay) command_from_child = C_ACK;
          else command_from_child = (spurious && $urandom_range(1, 0) == 1) ? pick_spur(1) : C_NOP;
        end
        C_SORT: begin
          hold++;
          if (hold > sdelay) begin
            command_from_child = C_SDONE;
            r = $urandom;
            data_from_child = {r[15:1], (pass + 1 == stable_pass)};
            responding = 1;
          end else begin
            command_from_child = (spurious && $urandom_range(1, 0) == 1) ? pick_spur(0) : C_NOP;
            data_from_child = 16'($urandom);
          end
        end
        default: begin
          hold = 0;
          command_from_child = C_NOP;
          if (responding) begin
            pass++;
            responding = 0;
            sdelay = $urandom_range(sd_max, sd_min);
          end
        end
      endcase
      start = poke && !fin && ($urandom_range(5, 0) == 0);
      prev = command_to_child;
      tick();
    end
    start = 1'b0;
    command_from_child = C_NOP;
    data_from_child = 16'h0;
    if (!fin) o_hung = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; cfg_axis = 2'd3;
    tick(); tick();
    start = 1'b0; rst = 1'b0;
    vectors++; if (command_to_child !== C_NOP) begin miscompares++; $display("FAIL reset_cmd: got %0d expected %0d", command_to_child, C_NOP); end
    vectors++; if (data_to_child !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h expected 0000", data_to_child); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
    vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %b expected 0", error); end
    vectors++; if (pass_count !== '0) begin miscompares++; $display("FAIL reset_pass_count: got %0d expected 0", pass_count); end
    tick();
  endtask

  task automatic test_nominal();
    run(2'd2, 5, 1, 0, 3, 0, 0);
    vectors++; if (o_cfg_data !== 16'h8000) begin miscompares++; $display("FAIL nominal_cfg_data: got %h expected 8000", o_cfg_data); end
    vectors++; if (o_dtl_first !== 2) begin miscompares++; $display("FAIL nominal_cmd_latency: got cycle %0d expected 2", o_dtl_first); end
    vectors++; if (o_sorts !== 1) begin miscompares++; $display("FAIL nominal_sorts: got %0d expected 1", o_sorts); end
    vectors++; if (o_done_cycles !== 1) begin miscompares++; $display("FAIL nominal_done_width: got %0d expected 1", o_done_cycles); end
    vectors++; if (o_pc_end !== 1) begin miscompares++; $display("FAIL nominal_pass_count: got %0d expected 1", o_pc_end); end
    vectors++; if (o_err_at !== -1) begin miscompares++; $display("FAIL nominal_error: got error at %0d expected none", o_err_at); end
    vectors++; if (o_busy_bad !== 1'b0 || o_hung !== 1'b0) begin miscompares++; $display("FAIL nominal_busy: busy_bad %0d hung %0d expected 0 0", o_busy_bad, o_hung); end
    vectors++; if (o_nop_after !== 0 || o_bad_data !== 1'b0) begin miscompares++; $display("FAIL nominal_release: non-nop %0d bad_data %0d expected 0 0", o_nop_after, o_bad_data); end
  endtask

  task automatic test_multi_pass();
    run(2'($urandom), $urandom_range(8, 0), 4, 0, 6, 0, 0);
    vectors++; if (o_sorts !== 4) begin miscompares++; $display("FAIL multi_sorts: got %0d expected 4", o_sorts); end
    vectors++; if (o_min_gap < 2) begin miscompares++; $display("FAIL multi_gap: got %0d nop cycles expected >=2", o_min_gap); end
    vectors++; if (o_pc_end !== 4) begin miscompares++; $display("FAIL multi_pass_count: got %0d expected 4", o_pc_end); end
    vectors++; if (o_done_cycles !== 1) begin miscompares++; $display("FAIL multi_done: got %0d expected 1", o_done_cycles); end
    vectors++; if (o_bad_data !== 1'b0) begin miscompares++; $display("FAIL multi_data: got bad_data %0d expected 0", o_bad_data); end
  endtask

  task automatic test_non_convergence();
    run(2'($urandom), $urandom_range(4, 0), 0, 0, 5, 0, 0);
    vectors++; if (o_err_at < 0) begin miscompares++; $display("FAIL nonconv_error: got none expected error"); end
    vectors++; if (o_done_cycles !== 0) begin miscompares++; $display("FAIL nonconv_done: got %0d expected 0", o_done_cycles); end
    vectors++; if (o_pc_end !== MAX_PASSES) begin miscompares++; $display("FAIL nonconv_pass_count: got %0d expected %0d", o_pc_end, MAX_PASSES); end
    vectors++; if (o_sorts !== MAX_PASSES) begin miscompares++; $display("FAIL nonconv_sorts: got %0d expected %0d", o_sorts, MAX_PASSES); end
    vectors++; if (o_err_cycles !== 5) begin miscompares++; $display("FAIL nonconv_sticky: got %0d cycles expected 5", o_err_cycles); end
    vectors++; if (o_nop_after !== 0 || o_busy_bad !== 1'b0) begin miscompares++; $display("FAIL nonconv_release: non-nop %0d busy_bad %0d expected 0 0", o_nop_after, o_busy_bad); end
  endtask

  task automatic test_timeout();
    run(2'd1, TIMEOUT, 1, 0, 3, 0, 0);
    vectors++; if (o_err_at - o_dtl_first !== TIMEOUT) begin miscompares++; $display("FAIL timeout_cfg_time: got %0d cycles expected %0d", o_err_at - o_dtl_first, TIMEOUT); end
    vectors++; if (o_sorts !== 0 || o_pc_end !== 0) begin miscompares++; $display("FAIL timeout_cfg_state: sorts %0d pass_count %0d expected 0 0", o_sorts, o_pc_end); end
    vectors++; if (o_nop_after !== 0) begin miscompares++; $display("FAIL timeout_cfg_nop: got %0d non-nop cycles expected 0", o_nop_after); end
    run(2'd3, TIMEOUT - 1, 1, 0, 3, 0, 0);
    vectors++; if (o_err_clear_bad !== 1'b0) begin miscompares++; $display("FAIL timeout_error_clear: error still set after start"); end
    vectors++; if (o_err_at !== -1 || o_done_cycles !== 1) begin miscompares++; $display("FAIL timeout_cfg_edge: error at %0d done %0d expected none 1", o_err_at, o_done_cycles); end
    run(2'd0, 0, 1, TIMEOUT, TIMEOUT, 0, 0);
    vectors++; if (o_err_at < 0 || o_sorts !== 1 || o_pc_end !== 0) begin miscompares++; $display("FAIL timeout_sort: error at %0d sorts %0d pass_count %0d expected error 1 0", o_err_at, o_sorts, o_pc_end); end
    run(2'd0, 0, 1, TIMEOUT - 1, TIMEOUT - 1, 0, 0);
    vectors++; if (o_err_at !== -1 || o_pc_end !== 1) begin miscompares++; $display("FAIL timeout_sort_edge: error at %0d pass_count %0d expected none 1", o_err_at, o_pc_end); end
  endtask

  task automatic test_reset_mid_sort();
    bit hit;
    hit = 0;
    cfg_axis = 2'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (command_to_child == C_SORT && pass_count == 1) begin
        hit = 1;
        break;
      end
      if (command_to_child == C_DTL) command_from_child = C_ACK;
      else if (command_to_child == C_SORT) command_from_child = C_SDONE;
      else command_from_child = C_NOP;
      data_from_child = 16'h0;
      tick();
    end
    rst = 1'b1;
    command_from_child = C_NOP;
    tick();
    rst = 1'b0;
    vectors++; if (hit !== 1'b1) begin miscompares++; $display("FAIL rstmid_reach: second pass not reached"); end
    vectors++; if (command_to_child !== C_NOP) begin miscompares++; $display("FAIL rstmid_cmd: got %0d expected %0d", command_to_child, C_NOP); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    vectors++; if (pass_count !== '0) begin miscompares++; $display("FAIL rstmid_pass_count: got %0d expected 0", pass_count); end
    tick(); tick();
    vectors++; if (command_to_child !== C_NOP || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: cmd %0d busy %b expected 0 0", command_to_child, busy); end
  endtask

  task automatic test_spurious();
    int sp;
    sp = $urandom_range(MAX_PASSES, 1);
    run(2'($urandom), 10, sp, 2, 8, 1, 1);
    vectors++; if (o_dtl_phases !== 1) begin miscompares++; $display("FAIL spurious_cfg_phases: got %0d expected 1", o_dtl_phases); end
    vectors++; if (o_done_cycles !== 1 || o_err_at !== -1) begin miscompares++; $display("FAIL spurious_outcome: done %0d error at %0d expected 1 none", o_done_cycles, o_err_at); end
    vectors++; if (o_pc_end !== sp || o_sorts !== sp) begin miscompares++; $display("FAIL spurious_passes: pass_count %0d sorts %0d expected %0d", o_pc_end, o_sorts, sp); end
    vectors++; if (o_busy_bad !== 1'b0 || o_bad_data !== 1'b0) begin miscompares++; $display("FAIL spurious_busy_data: busy_bad %0d bad_data %0d expected 0 0", o_busy_bad, o_bad_data); end
  endtask

  task automatic test_random();
    bit exp_done;
    int exp_pc, exp_sorts, ack, sp, sdm;
    for (int i = 0; i < 24; i++) begin
      ack = $urandom_range(TIMEOUT + 1, 0);
      sp  = $urandom_range(MAX_PASSES + 1, 0);
      sdm = $urandom_range(TIMEOUT - 1, 0);
      model(ack, sp, sdm, exp_done, exp_pc, exp_sorts);
      run(2'($urandom), ack, sp, 0, sdm, 1'($urandom), 1'($urandom));
      vectors++; if ((o_done_cycles == 1) !== exp_done || (o_err_at >= 0) === exp_done) begin miscompares++; $display("FAIL rand%0d_outcome: done %0d error at %0d expected done=%0d", i, o_done_cycles, o_err_at, exp_done); end
      vectors++; if (o_pc_end !== exp_pc) begin miscompares++; $display("FAIL rand%0d_pass_count: got %0d expected %0d", i, o_pc_end, exp_pc); end
      vectors++; if (o_sorts !== exp_sorts) begin miscompares++; $display("FAIL rand%0d_sorts: got %0d expected %0d", i, o_sorts, exp_sorts); end
      vectors++; if (o_dtl_phases !== 1 || o_dtl_first !== 2) begin miscompares++; $display("FAIL rand%0d_cfg: phases %0d first %0d expected 1 2", i, o_dtl_phases, o_dtl_first); end
      vectors++; if (o_bad_data || o_busy_bad || o_hung || o_nop_after != 0 || (o_sorts > 1 && o_min_gap < 2)) begin miscompares++; $display("FAIL rand%0d_protocol: bad_data %0d busy_bad %0d hung %0d non-nop %0d gap %0d", i, o_bad_data, o_busy_bad, o_hung, o_nop_after, o_min_gap); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_axis = 2'd0;
    command_from_child = C_NOP;
    data_from_child = 16'h0;
    test_reset();
    test_nominal();
    test_multi_pass();
    test_non_convergence();
    test_timeout();
    test_reset_mid_sort();
    test_spurious();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
